// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the sweep controller.
// Holds state encoding, code width and the default expected table.
package tt_sweep_pkg;

  localparam int CODE_W = 4;

  localparam logic [63:0] EXP_TABLE_DEF = 64'h4121_7CF9_DAB3_0832;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_exp_lookup.sv
// Expected-response lookup: selects nibble [4*code+3:4*code] of TABLE.
// Ports: code (4-bit code under test), exp (expected 4-bit response).
module tt_exp_lookup
  import tt_sweep_pkg::*;
#(
  parameter logic [63:0] TABLE = EXP_TABLE_DEF
) (
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] exp
);

  assign exp = TABLE[{code, 2'b00} +: CODE_W];

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive 16-code sweep of an external 4-in/4-out unit vs a table.
// Ports: clk, rst (sync, active-high), start, abort, x (code out),
//   y (unit response), busy, done, pass, err_cnt, first_err,
//   err_valid, fail_map.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [63:0] EXP_TABLE     = EXP_TABLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [CODE_W-1:0] x,
  input  logic [CODE_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_cnt,
  output logic [CODE_W-1:0] first_err,
  output logic              err_valid,
  output logic [15:0]       fail_map
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [CODE_W-1:0] exp;

  tt_exp_lookup #(
    .TABLE(EXP_TABLE)
  ) u_lookup (
    .code(x),
    .exp (exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
      err_valid <= 1'b0;
      fail_map  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x         <= '0;
            cnt       <= SETTLE;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
            err_valid <= 1'b0;
            fail_map  <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          // abort pre-empts the compare of the current code
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else begin
            if (y != exp) begin
              fail_map[x] <= 1'b1;
              if (err_cnt != 5'd16) begin
                err_cnt <= err_cnt + 5'd1;
              end
              if (!err_valid) begin
                first_err <= x;
                err_valid <= 1'b1;
              end
            end
            if (x != 4'd15) begin
              x     <= x + 4'd1;
              cnt   <= SETTLE;
              state <= HOLD;
            end else begin
              busy  <= 1'b0;
              state <= FIN;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          pass  <= (err_cnt == 5'd0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (settle 0 and 2) on one stimulus,
// checked every cycle against a timing-arithmetic sweep model.
module tb_tt_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  logic [3:0] x0, y0, x2, y2;
  logic busy0, done0, pass0, ev0;
  logic busy2, done2, pass2, ev2;
  logic [4:0] ec0, ec2;
  logic [3:0] fe0, fe2;
  logic [15:0] fm0, fm2;

  logic [63:0] exp_tab = 64'h4121_7CF9_DAB3_0832;
  logic [3:0] flip [16];

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  function automatic logic [3:0] nib(input logic [3:0] c);
    return exp_tab[{c, 2'b00} +: 4];
  endfunction

  always_comb y0 = nib(x0) ^ flip[x0];
  always_comb y2 = nib(x2) ^ flip[x2];

  tt_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x(x0), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(ec0), .first_err(fe0), .err_valid(ev0), .fail_map(fm0)
  );

  tt_sweep_ctrl #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x(x2), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(ec2), .first_err(fe2), .err_valid(ev2), .fail_map(fm2)
  );

  // Model: n counts edges since the start-accept edge; code i is
  // checked at edge (i+1)*p where p = settle + 2.
  typedef struct {
    bit run;
    bit fin;
    int n;
    int p;
    logic [3:0] x;
    logic busy, done, pass, ev;
    logic [4:0] cnt;
    logic [3:0] first;
    logic [15:0] fmap;
  } model_t;

  model_t m [2];

  function automatic void step(inout model_t s,
                               input logic r, input logic st,
                               input logic ab);
    int i;
    if (r) begin
      s.run = 0; s.fin = 0; s.n = 0; s.x = 0;
      s.busy = 0; s.done = 0; s.pass = 0; s.ev = 0;
      s.cnt = 0; s.first = 0; s.fmap = 0;
    end else if (s.run) begin
      if (ab) begin
        s.run = 0; s.busy = 0; s.pass = 0;
      end else begin
        s.n++;
        if (s.n % s.p == 0) begin
          i = s.n / s.p - 1;
          if (flip[i[3:0]] != 4'd0) begin
            s.fmap[i] = 1'b1;
            if (s.cnt < 5'd16) s.cnt++;
            if (!s.ev) begin
              s.ev = 1;
              s.first = i[3:0];
            end
          end
          if (i < 15) s.x = 4'(i + 1);
          else begin
            s.run = 0; s.fin = 1; s.busy = 0;
          end
        end
      end
    end else if (s.fin) begin
      s.fin = 0; s.done = 1; s.pass = (s.cnt == 0);
    end else begin
      s.done = 0;
      if (st) begin
        s.run = 1; s.n = 0; s.x = 0; s.busy = 1; s.pass = 0;
        s.cnt = 0; s.ev = 0; s.first = 0; s.fmap = 0;
      end
    end
  endfunction

  function automatic logic [32:0] mpack(input model_t s);
    return {s.x, s.busy, s.done, s.pass, s.cnt, s.first, s.ev, s.fmap};
  endfunction

  logic [32:0] got0, got2;
  assign got0 = {x0, busy0, done0, pass0, ec0, fe0, ev0, fm0};
  assign got2 = {x2, busy2, done2, pass2, ec2, fe2, ev2, fm2};

  always @(posedge clk) begin
    step(m[0], rst, start, abort);
    step(m[1], rst, start, abort);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (got0 !== mpack(m[0])) begin
        errors++;
        $display("FAIL model_s0 t=%0t got %h exp %h",
                 $time, got0, mpack(m[0]));
      end
      checks++;
      if (got2 !== mpack(m[1])) begin
        errors++;
        $display("FAIL model_s2 t=%0t got %h exp %h",
                 $time, got2, mpack(m[1]));
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start pulse, optional re-pulse at cycle 10, latency of both dones.
  task automatic sweep(input bit repulse, output int d0, output int d2);
    d0 = -1;
    d2 = -1;
    start = 1;
    tick;
    for (int k = 1; k <= 200 && d2 < 0; k++) begin
      start = repulse && (k == 10);
      tick;
      if (done0 && d0 < 0) d0 = k;
      if (done2 && d2 < 0) d2 = k;
    end
    start = 0;
  endtask

  initial begin
    int d0, d2, seen;
    rst = 1; start = 0; abort = 0;
    for (int i = 0; i < 16; i++) flip[i] = 4'd0;
    m[0].p = 2;
    m[1].p = 4;
    tick;
    tick;
    chk_on = 1;
    rst = 0;
    check("rst_out_s0", {31'd0, got0 != 33'd0}, 32'd0);
    check("rst_out_s2", {31'd0, got2 != 33'd0}, 32'd0);

    sweep(1'b1, d0, d2);
    check("lat_s0", d0, 33);
    check("lat_s2", d2, 65);
    check("good_pass", pass2, 1);
    check("good_cnt", ec2, 0);
    check("good_map", fm2, 0);
    check("good_pass_s0", pass0, 1);
    tick;

    flip[3] = 4'hF;
    flip[12] = 4'hF;
    sweep(1'b0, d0, d2);
    check("inv_lat", d2, 65);
    check("inv_cnt", ec2, 2);
    check("inv_map", fm2, 16'h1008);
    check("inv_first", fe2, 3);
    check("inv_ev", ev2, 1);
    check("inv_pass", pass2, 0);
    tick;

    for (int i = 0; i < 16; i++) flip[i] = nib(4'(i));
    sweep(1'b0, d0, d2);
    check("stuck_cnt", ec2, 15);
    check("stuck_first", fe2, 0);
    check("stuck_map", fm2, 16'hFFF7);
    tick;

    start = 1;
    tick;
    start = 0;
    repeat (19) tick;
    abort = 1;
    tick;
    abort = 0;
    check("abort_busy_s2", busy2, 0);
    check("abort_busy_s0", busy0, 0);
    check("abort_cnt_s2", ec2, 3);
    check("abort_map_s2", fm2, 16'h0007);
    check("abort_ev_s2", ev2, 1);
    check("abort_cnt_s0", ec0, 8);
    check("abort_map_s0", fm0, 16'h01F7);
    seen = 0;
    repeat (80) begin
      tick;
      if (done0 || done2) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_pass", pass2, 0);
    check("abort_hold", fm2, 16'h0007);

    start = 1;
    tick;
    start = 0;
    repeat (29) tick;
    rst = 1;
    tick;
    rst = 0;
    check("mid_rst_s2", {31'd0, got2 != 33'd0}, 32'd0);
    check("mid_rst_s0", {31'd0, got0 != 33'd0}, 32'd0);
    for (int i = 0; i < 16; i++) flip[i] = 4'd0;
    sweep(1'b0, d0, d2);
    check("fresh_lat", d2, 65);
    check("fresh_pass", pass2, 1);

    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 249) == 0);
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 59) == 0) begin
        for (int i = 0; i < 16; i++)
          flip[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      end
      tick;
    end
    start = 0;
    abort = 0;
    rst = 0;
    repeat (3) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, range 0..15: extra cycles each code is held before its output is sampled.
REQ-002 Parameter EXP_TABLE, 64 bits, default 64'h4121_7CF9_DAB3_0832: expected 4-bit output for code i in bits [4i+3:4i].
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  begins a sweep when sampled high in IDLE.
REQ-006 abort  input  1  terminates a running sweep.
REQ-007 x  output  4  code driven to the external 4-in/4-out combinational unit; x[3] maps to x3 and x[0] to x0.
REQ-008 y  input  4  unit response; y[3] is y3 and y[0] is y0.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-011 pass  output  1  high after a completed sweep with zero mismatches.
REQ-012 err_cnt  output  5  mismatch count of the last sweep, 0..16.
REQ-013 first_err  output  4  lowest failing code of the last sweep.
REQ-014 err_valid  output  1  first_err is meaningful, i.e. err_cnt is non-zero.
REQ-015 fail_map  output  16  bit i is set when code i mismatched.

Function
REQ-016 The FSM shall have four states: IDLE, HOLD, CHECK and FIN.
REQ-017 IDLE with start=1: x set to 0, hold counter set to SETTLE_CYCLES, all results cleared, next state HOLD.
REQ-018 HOLD: counter decrements each cycle; with counter=0 the next state is CHECK.
REQ-019 With SETTLE_CYCLES=0, HOLD shall last exactly one cycle.
REQ-020 CHECK: y compared with EXP_TABLE nibble[x] in that cycle.
REQ-021 On a CHECK mismatch: fail_map[x] set and err_cnt incremented; first_err and err_valid loaded only if err_valid is 0.
REQ-022 CHECK with x<15: x incremented, counter reloaded, next state HOLD.
REQ-023 CHECK with x=15: next state FIN; x does not wrap.
REQ-024 FIN: done=1 for exactly one cycle, pass=(err_cnt==0), next state IDLE.
REQ-025 Each code shall be driven for SETTLE_CYCLES+2 cycles.
REQ-026 done shall assert 16*(SETTLE_CYCLES+2)+1 cycles after the start-accept edge.
REQ-027 busy shall be high in HOLD and CHECK and low in IDLE and FIN.
REQ-028 start while busy shall be ignored.
REQ-029 start in FIN shall be ignored.
REQ-030 abort while busy: next state IDLE, no done, pass=0, partial fail_map, err_cnt and first_err retained.
REQ-031 abort and start high in the same IDLE cycle: start wins.
REQ-032 abort in IDLE or FIN shall have no effect.
REQ-033 Result outputs shall hold their values in IDLE until the next accepted start.
REQ-034 err_cnt shall saturate at 16, with no wrap.
REQ-035 x shall be registered and change only on entry to HOLD.

Reset
REQ-036 When rst is high at a clock edge, on that edge: state IDLE, x=0, counter=0, busy=0, done=0, pass=0, err_cnt=0, first_err=0, err_valid=0, fail_map=0.
REQ-037 rst shall override start and abort, including mid-sweep; done shall not pulse.

Structure
REQ-038 State encoding, default EXP_TABLE and code width (4) shall live in package tt_sweep_pkg.
REQ-039 Sub-module tt_exp_lookup (combinational nibble select of EXP_TABLE by code) shall be used.
REQ-040 The 4-in/4-out unit shall be external and shall not be instantiated inside the block.

Verification
REQ-041 Correct unit model, SETTLE_CYCLES=2, start pulse -> done 65 cycles later, pass=1, err_cnt=0, fail_map=0.
REQ-042 Model with y inverted for codes 3 and 12 -> err_cnt=2, fail_map=16'h1008, first_err=3, err_valid=1, pass=0.
REQ-043 All outputs stuck at 0 -> err_cnt=15, first_err=0, fail_map=16'hFFF7 (code 3 expects 0).
REQ-044 SETTLE_CYCLES=0 -> done 33 cycles after start; start re-pulsed at cycle 10 is ignored.
REQ-045 abort at cycle 20 (SETTLE_CYCLES=2) -> busy low next cycle, no done, pass=0, partial results held.
REQ-046 rst at cycle 30 -> all outputs 0 next cycle; a fresh start then yields a full 65-cycle sweep.
